// File: rtl/full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : Registered 6:3 column counter (sum bit + 2-bit carry) for the
//               TD4 ALU adder chain; classic full adder on bit 0 of each input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] IN_Y,
  input  logic [1:0] IN_DATA,
  input  logic [1:0] CIN,
  output logic       DATA,
  output logic [1:0] CRR
);

  // Ones count over all six input bits; max 6 fits in 3 bits.
  logic [2:0] ones_count;

  always_comb begin
    ones_count = {2'b00, IN_Y[0]}    + {2'b00, IN_Y[1]}
               + {2'b00, IN_DATA[0]} + {2'b00, IN_DATA[1]}
               + {2'b00, CIN[0]}     + {2'b00, CIN[1]};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DATA <= 1'b0;
      CRR  <= 2'b00;
    end else begin
      DATA <= ones_count[0];
      CRR  <= ones_count[2:1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_full_adder.sv
// ============================================================================
// Module      : tb_full_adder
// Description : Scoreboard bench for full_adder using directed vectors and a
//               64-pattern sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_full_adder;

  logic       CLK;
  logic       RST_N;
  logic [1:0] IN_Y;
  logic [1:0] IN_DATA;
  logic [1:0] CIN;
  logic       DATA;
  logic [1:0] CRR;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0] exp_q[$];
  string      name_q[$];

  full_adder dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .IN_Y    (IN_Y),
    .IN_DATA (IN_DATA),
    .CIN     (CIN),
    .DATA    (DATA),
    .CRR     (CRR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [2:0] exp);
    n_cmp++;
    if ({CRR, DATA} !== exp) begin
      n_err++;
      $display("FAIL %s: got {CRR,DATA}=%b, expected %b", name, {CRR, DATA}, exp);
    end
  endtask

  // Drive inputs between edges; the result is due after the next rising edge.
  task automatic apply(input string name, input logic [1:0] y, input logic [1:0] d,
                       input logic [1:0] c, input logic [2:0] exp);
    @(negedge CLK);
    IN_Y    = y;
    IN_DATA = d;
    CIN     = c;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge CLK);
      #2;
      n++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // Monitor: the DUT presents a result every cycle; pop one expectation per edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        logic [2:0] e;
        string      nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N   = 1'b0;
    IN_Y    = 2'b11;
    IN_DATA = 2'b11;
    CIN     = 2'b11;

    // Reset holds outputs at zero despite all-ones inputs.
    #1;
    check("reset_async", 3'b000);
    for (int i = 0; i < 3; i++) apply("reset_hold", 2'b11, 2'b11, 2'b11, 3'b000);
    drain();
    RST_N = 1'b1;
    apply("reset_release", 2'b11, 2'b11, 2'b11, 3'b110);

    apply("fa_zero",   2'b00, 2'b00, 2'b00, 3'b000);
    apply("fa_y",      2'b01, 2'b00, 2'b00, 3'b001);
    apply("fa_y_d",    2'b01, 2'b01, 2'b00, 3'b010);
    apply("fa_y_d_c",  2'b01, 2'b01, 2'b01, 3'b011);
    apply("fa_y_c",    2'b01, 2'b00, 2'b01, 3'b010);
    apply("fa_c",      2'b00, 2'b00, 2'b01, 3'b001);
    apply("upper_bits", 2'b10, 2'b10, 2'b10, 3'b011);
    apply("n5",        2'b11, 2'b11, 2'b01, 3'b101);

    for (int i = 0; i < 64; i++) begin
      logic [5:0] p;
      p = i[5:0];
      apply($sformatf("sweep_%0d", i), p[5:4], p[3:2], p[1:0], 3'($countones(p)));
    end
    drain();

    // Async reset between edges clears outputs without a clock edge.
    apply("pre_async_n5", 2'b11, 2'b01, 2'b11, 3'b101);
    drain();
    RST_N = 1'b0;
    #1;
    check("async_clear", 3'b000);
    @(negedge CLK);
    check("async_hold", 3'b000);
    RST_N   = 1'b1;
    IN_Y    = 2'b01;
    IN_DATA = 2'b01;
    CIN     = 2'b00;
    exp_q.push_back(3'b010);
    name_q.push_back("async_fresh");
    drain();

    // Latency: inputs changed just after an edge must not show until the next one.
    apply("lat_base", 2'b11, 2'b00, 2'b00, 3'b010);
    drain();
    IN_Y    = 2'b11;
    IN_DATA = 2'b11;
    CIN     = 2'b11;
    exp_q.push_back(3'b110);
    name_q.push_back("lat_new");
    #5;
    check("lat_hold", 3'b010);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
